// File: rtl/msg_stream_scheduler.sv
// ---------------------------------------------------------------------------
// msg_stream_scheduler
//
// Plays stored messages from a shared character ROM onto a display output.
// Each of NUM_REQ requesters owns one message, described by a base address
// and a length. Requesters are served in non-preemptive round-robin order.
// A granted message plays to the end: one character per DWELL-cycle dwell
// period, followed by a DWELL-cycle BLANK gap. After that the next requester
// is picked.
//
// Ports
//   clk, rst    rising-edge clock; asynchronous active-high reset
//   req         level request per message (sampled only while idle)
//   msg_base    packed base addresses, slice i belongs to message i
//   msg_len     packed lengths in characters, 0 = empty message
//   pause       freezes the sequencer and the dwell counter
//   abort       ends the current message at once (takes priority over pause)
//   rom_en      ROM read strobe
//   rom_addr    ROM read address
//   rom_data    ROM read data, valid the cycle after rom_en
//   char_out    displayed character
//   char_valid  high while char_out holds a message character
//   grant       one-hot owner of the current message, 0 when idle
//   busy        high whenever the sequencer is not idle
//   done        one-cycle pulse when a message finishes or is aborted
// ---------------------------------------------------------------------------
module msg_stream_scheduler #(
    parameter int         NUM_REQ = 4,
    parameter int         ADDR_W  = 8,
    parameter int         DWELL   = 1000,
    parameter logic [7:0] BLANK   = 8'h20
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*ADDR_W-1:0] msg_base,
    input  logic [NUM_REQ*ADDR_W-1:0] msg_len,
    input  logic                      pause,
    input  logic                      abort,
    output logic                      rom_en,
    output logic [ADDR_W-1:0]         rom_addr,
    input  logic [7:0]                rom_data,
    output logic [7:0]                char_out,
    output logic                      char_valid,
    output logic [NUM_REQ-1:0]        grant,
    output logic                      busy,
    output logic                      done
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(DWELL + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD,
        SHOW,
        GAP
    } state_t;

    state_t            state;
    logic [PTR_W-1:0]  rr_ptr;
    logic [ADDR_W-1:0] base_r;
    logic [ADDR_W-1:0] len_r;
    logic [ADDR_W-1:0] idx;
    logic [CNT_W-1:0]  cnt;

    logic              sel_found;
    logic [PTR_W-1:0]  sel_idx;
    logic [PTR_W-1:0]  sel_next;
    logic [ADDR_W-1:0] sel_base;
    logic [ADDR_W-1:0] sel_len;

    // Circular search for the first active request at or after rr_ptr.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int off = 0; off < NUM_REQ; off++) begin
            if (!sel_found && req[(int'(rr_ptr) + off) % NUM_REQ]) begin
                sel_found = 1'b1;
                sel_idx   = PTR_W'((int'(rr_ptr) + off) % NUM_REQ);
            end
        end
        sel_next = (int'(sel_idx) == NUM_REQ - 1) ? '0 : sel_idx + PTR_W'(1);
        sel_base = msg_base[int'(sel_idx)*ADDR_W +: ADDR_W];
        sel_len  = msg_len[int'(sel_idx)*ADDR_W +: ADDR_W];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            rr_ptr     <= '0;
            base_r     <= '0;
            len_r      <= '0;
            idx        <= '0;
            cnt        <= '0;
            grant      <= '0;
            rom_en     <= 1'b0;
            rom_addr   <= '0;
            char_out   <= BLANK;
            char_valid <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == IDLE) begin
                // grant and done are single-cycle in IDLE unless re-armed here
                grant <= '0;
                if (sel_found && !pause) begin
                    grant  <= NUM_REQ'(1) << sel_idx;
                    base_r <= sel_base;
                    len_r  <= sel_len;
                    idx    <= '0;
                    rr_ptr <= sel_next;
                    if (sel_len == '0) begin
                        done <= 1'b1;
                    end else begin
                        state    <= FETCH;
                        busy     <= 1'b1;
                        rom_en   <= 1'b1;
                        rom_addr <= sel_base;
                    end
                end
            end else if (abort) begin
                state      <= IDLE;
                busy       <= 1'b0;
                grant      <= '0;
                done       <= 1'b1;
                rom_en     <= 1'b0;
                char_out   <= BLANK;
                char_valid <= 1'b0;
            end else if (pause) begin
                // A read dropped here is re-issued from FETCH after release.
                rom_en <= 1'b0;
            end else begin
                case (state)
                    FETCH: begin
                        if (rom_en) begin
                            rom_en <= 1'b0;
                            state  <= LOAD;
                        end else begin
                            rom_en <= 1'b1;
                        end
                    end
                    LOAD: begin
                        char_out   <= rom_data;
                        char_valid <= 1'b1;
                        cnt        <= '0;
                        state      <= SHOW;
                    end
                    SHOW: begin
                        if (cnt == CNT_LAST) begin
                            cnt <= '0;
                            if (idx == len_r - ADDR_W'(1)) begin
                                state      <= GAP;
                                char_out   <= BLANK;
                                char_valid <= 1'b0;
                            end else begin
                                idx      <= idx + ADDR_W'(1);
                                rom_addr <= base_r + idx + ADDR_W'(1);
                                rom_en   <= 1'b1;
                                state    <= FETCH;
                            end
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                    GAP: begin
                        if (cnt == CNT_LAST) begin
                            cnt   <= '0;
                            state <= IDLE;
                            busy  <= 1'b0;
                            grant <= '0;
                            done  <= 1'b1;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule
